// File: rtl/add_op_impl_chunked_if.sv
// Handshake bus for the chunked add/sub operation: request side plus result/flags side.
interface add_op_impl_chunked_if #(
    parameter int unsigned OPERAND_WIDTH = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OPERAND_WIDTH-1:0] lhs;
    logic [OPERAND_WIDTH-1:0] rhs;
    logic                     sub;
    logic                     carry_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPERAND_WIDTH-1:0] result;
    logic                     carry_out;
    logic                     overflow;
    logic                     zero;

    // Producer/consumer side of the operation.
    modport master (
        output in_valid, lhs, rhs, sub, carry_in, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero
    );

    // Arithmetic unit side.
    modport slave (
        input  in_valid, lhs, rhs, sub, carry_in, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/add_op_impl_chunked.sv
// Multi-cycle add/sub: one CHUNK_WIDTH slice per clock with a registered ripple carry.
module add_op_impl_chunked #(
    parameter int unsigned OPERAND_WIDTH = 32,
    parameter int unsigned CHUNK_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    add_op_impl_chunked_if.slave  bus
);
    localparam int unsigned NUM_CHUNKS = OPERAND_WIDTH / CHUNK_WIDTH;
    localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int unsigned MSB        = OPERAND_WIDTH - 1;

    // Reject parameter sets that cannot be split into whole chunks.
    if (OPERAND_WIDTH < 1 || CHUNK_WIDTH < 1 || (OPERAND_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_params
        $error("add_op_impl_chunked: OPERAND_WIDTH must be a nonzero multiple of CHUNK_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic                     accept_c;
    logic                     last_c;

    logic [OPERAND_WIDTH-1:0] lhs_q;
    logic [OPERAND_WIDTH-1:0] rhs_q;
    logic [OPERAND_WIDTH-1:0] acc_q;
    logic [OPERAND_WIDTH-1:0] acc_c;
    logic                     carry_q;
    logic [IDX_W-1:0]         idx_q;
    logic [CHUNK_WIDTH:0]     sum_c;
    int unsigned              base_c;

    logic [OPERAND_WIDTH-1:0] result_q;
    logic                     carry_out_q;
    logic                     overflow_q;
    logic                     zero_q;

    assign last_c = (idx_q == IDX_W'(NUM_CHUNKS - 1));

    // State and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and next handshake values.
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        accept_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept_c   = 1'b1;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                end
            end
            BUSY: begin
                if (last_c) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Current chunk sum and the accumulator with that slice filled in.
    always_comb begin
        base_c = 32'(idx_q) * CHUNK_WIDTH;
        sum_c  = {1'b0, lhs_q[base_c +: CHUNK_WIDTH]}
               + {1'b0, rhs_q[base_c +: CHUNK_WIDTH]}
               + (CHUNK_WIDTH + 1)'(carry_q);
        acc_c  = acc_q;
        acc_c[base_c +: CHUNK_WIDTH] = sum_c[CHUNK_WIDTH-1:0];
    end

    // Operand capture, chunk ripple, and result/flag update on the final chunk.
    always_ff @(posedge clk) begin
        if (reset) begin
            lhs_q       <= '0;
            rhs_q       <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (accept_c) begin
            lhs_q   <= bus.lhs;
            rhs_q   <= bus.sub ? ~bus.rhs : bus.rhs;
            carry_q <= bus.sub | bus.carry_in;
            idx_q   <= '0;
        end else if (state_q == BUSY) begin
            acc_q   <= acc_c;
            carry_q <= sum_c[CHUNK_WIDTH];
            idx_q   <= idx_q + IDX_W'(1);
            if (last_c) begin
                result_q    <= acc_c;
                carry_out_q <= sum_c[CHUNK_WIDTH];
                overflow_q  <= (lhs_q[MSB] == rhs_q[MSB]) && (acc_c[MSB] != lhs_q[MSB]);
                zero_q      <= (acc_c == '0);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule
